// File: rtl/wb_boot_fetch.sv
// rtl/wb_boot_fetch.sv - Wishbone read master fetching boot words into PRAM
// One fetch per start_in, with timeout, bounded retries and a sticky error.
module wb_boot_fetch #(
    parameter int                DATA_WL   = 16,
    parameter int                ADR_WL    = 12,
    parameter logic [ADR_WL-1:0] BASE_ADR  = '0,
    parameter int                TMO_CYC   = 15,
    parameter int                RETRY_MAX = 2
) (
    input  logic               clk,
    input  logic               a_reset_l,
    input  logic               start_in,
    input  logic [ADR_WL-1:0]  adr_in,
    input  logic               abort_in,
    input  logic [DATA_WL-1:0] wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    output logic [ADR_WL-1:0]  wb_adr_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [DATA_WL-1:0] data_out,
    output logic               ack_out,
    output logic               err_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ERR
    } state_t;

    // The waiting cycle that would bring the count to TMO_CYC ends the attempt,
    // so each attempt keeps cyc/stb high for exactly TMO_CYC cycles.
    localparam logic [3:0] TMO_LAST  = 4'(TMO_CYC - 1);
    localparam logic [1:0] RETRY_LIM = 2'(RETRY_MAX);

    state_t              r_state;
    logic [3:0]          r_tmo_cnt;
    logic [1:0]          r_retry;
    logic [ADR_WL-1:0]   r_adr;
    logic [DATA_WL-1:0]  r_data;
    logic                r_cyc;
    logic                r_ack;
    logic                r_err;

    logic                w_fail;

    assign w_fail = wb_err_i || (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            r_retry   <= '0;
            r_adr     <= '0;
            r_data    <= '0;
            r_cyc     <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else if (abort_in) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            r_retry   <= '0;
            r_cyc     <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (start_in) begin
                        r_adr     <= BASE_ADR + adr_in;
                        r_cyc     <= 1'b1;
                        r_ack     <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_retry   <= '0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // cyc low inside REQ is the one-cycle gap before a re-issue
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_data  <= wb_dat_i;
                        r_cyc   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_HOLD;
                    end else if (w_fail) begin
                        r_cyc     <= 1'b0;
                        r_tmo_cnt <= '0;
                        if (r_retry < RETRY_LIM) begin
                            r_retry <= r_retry + 2'd1;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end else if (r_tmo_cnt != 4'hF) begin
                        r_tmo_cnt <= r_tmo_cnt + 4'd1;
                    end
                end
                S_ERR: begin
                    r_cyc <= 1'b0;
                    r_ack <= 1'b0;
                    r_err <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign wb_adr_o = r_adr;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = 1'b0;
    assign data_out = r_data;
    assign ack_out  = r_ack;
    assign err_out  = r_err;

endmodule

// File: tb/tb_wb_boot_fetch.sv
// tb/tb_wb_boot_fetch.sv - randomized fetch plans checked against a transaction model
module tb_wb_boot_fetch;

    localparam int         DW   = 16;
    localparam int         AW   = 12;
    localparam int         TMO  = 15;
    localparam int         RMAX = 2;
    localparam logic [11:0] BASE = 12'h100;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_TMO  = 2;
    localparam int K_BOTH = 3;

    logic          clk = 1'b0;
    logic          a_reset_l = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] adr_in = '0;
    logic          abort_in = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;
    logic [AW-1:0] wb_adr_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [DW-1:0] data_out;
    logic          ack_out;
    logic          err_out;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_data = '0;
    int            plan_n;
    int            plan_kind [3];
    int            plan_dly  [3];

    always #5 clk = ~clk;

    wb_boot_fetch #(
        .DATA_WL(DW), .ADR_WL(AW), .BASE_ADR(BASE), .TMO_CYC(TMO), .RETRY_MAX(RMAX)
    ) dut (
        .clk(clk), .a_reset_l(a_reset_l), .start_in(start_in), .adr_in(adr_in),
        .abort_in(abort_in), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .data_out(data_out), .ack_out(ack_out), .err_out(err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one fetch and act as the slave following the plan; expectations
    // come from attempt lengths and the retry/error rules, not from DUT state.
    task automatic fetch(input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        logic [AW-1:0] exp_adr;
        int cnt;
        int len;
        bit resp_ack;
        exp_adr = BASE + adr;
        start_in = 1'b1;
        adr_in   = adr;
        @(negedge clk);
        start_in = 1'b0;
        adr_in   = AW'($urandom);
        for (int a = 0; a < plan_n; a++) begin
            cnt = 0;
            len = (plan_kind[a] == K_TMO) ? TMO : plan_dly[a] + 1;
            resp_ack = (plan_kind[a] == K_ACK) || (plan_kind[a] == K_BOTH);
            while (wb_cyc_o && cnt < 40) begin
                cnt++;
                if (cnt == 1) begin
                    check("adr", wb_adr_o, exp_adr);
                    check("stb", wb_stb_o, 1);
                    check("we", wb_we_o, 0);
                end
                wb_dat_i = DW'($urandom);
                if (plan_kind[a] != K_TMO && cnt == len) begin
                    wb_ack_i = resp_ack;
                    wb_err_i = (plan_kind[a] == K_ERR) || (plan_kind[a] == K_BOTH);
                    if (resp_ack) wb_dat_i = dat;
                end
                @(negedge clk);
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
            check("att_len", cnt, len);
            if (a < plan_n - 1) begin
                check("gap_err", err_out, 0);
                check("gap_ack", ack_out, 0);
                @(negedge clk);
                check("regap", wb_cyc_o, 1);
            end
        end
        if (plan_kind[plan_n-1] == K_ACK || plan_kind[plan_n-1] == K_BOTH) begin
            exp_data = dat;
            check("done_ack", ack_out, 1);
            check("done_err", err_out, 0);
        end else begin
            check("fail_err", err_out, 1);
            check("fail_ack", ack_out, 0);
        end
        check("done_cyc", wb_cyc_o, 0);
        check("done_data", data_out, exp_data);
    endtask

    task automatic hold_check(input int n, input logic exp_ack);
        for (int i = 0; i < n; i++) begin
            wb_dat_i = DW'($urandom);
            wb_ack_i = 1'($urandom);
            @(negedge clk);
            check("hold_ack", ack_out, exp_ack);
            check("hold_data", data_out, exp_data);
            check("hold_cyc", wb_cyc_o, 0);
        end
        wb_ack_i = 1'b0;
    endtask

    task automatic do_abort();
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check("abort_cyc", wb_cyc_o, 0);
        check("abort_ack", ack_out, 0);
        check("abort_err", err_out, 0);
        check("abort_data", data_out, exp_data);
    endtask

    task automatic err_exit();
        start_in = 1'b1;
        adr_in   = AW'($urandom);
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        check("err_start_cyc", wb_cyc_o, 0);
        check("err_sticky", err_out, 1);
        check("err_ack", ack_out, 0);
        do_abort();
    endtask

    task automatic set_plan1(input int k, input int d);
        plan_n = 1;
        plan_kind[0] = k;
        plan_dly[0]  = d;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_adr", wb_adr_o, 0);
        check("rst_data", data_out, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_ack", ack_out, 0);
        check("rst_err", err_out, 0);
        check("rst_we", wb_we_o, 0);
        a_reset_l = 1'b1;
        @(negedge clk);

        set_plan1(K_ACK, 2);
        fetch(12'h005, 16'hBEEF);
        check("adr_105", wb_adr_o, 12'h105);
        hold_check(3, 1'b1);

        set_plan1(K_ACK, 0);
        fetch(12'hF80, 16'h1234);
        check("adr_wrap", wb_adr_o, 12'h080);

        plan_n = 3;
        plan_kind[0] = K_ERR; plan_dly[0] = 1;
        plan_kind[1] = K_ERR; plan_dly[1] = 0;
        plan_kind[2] = K_ACK; plan_dly[2] = 3;
        fetch(12'h2A0, 16'hC0DE);

        plan_n = 3;
        for (int i = 0; i < 3; i++) plan_kind[i] = K_TMO;
        fetch(12'h010, 16'h0000);
        err_exit();

        set_plan1(K_BOTH, 1);
        fetch(12'h333, 16'h5A5A);

        start_in = 1'b1;
        adr_in   = 12'h044;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'hDEAD;
        do_abort();
        wb_ack_i = 1'b0;
        hold_check(2, 1'b0);

        start_in = 1'b1;
        adr_in   = 12'h055;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        #2 a_reset_l = 1'b0;
        #1;
        check("arst_cyc", wb_cyc_o, 0);
        check("arst_stb", wb_stb_o, 0);
        check("arst_ack", ack_out, 0);
        check("arst_data", data_out, 0);
        exp_data = '0;
        @(negedge clk);
        a_reset_l = 1'b1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("post_rst_ack", ack_out, 0);
        check("post_rst_cyc", wb_cyc_o, 0);
        set_plan1(K_ACK, 4);
        fetch(12'h066, 16'hA55A);

        for (int it = 0; it < 40; it++) begin
            int f;
            f = $urandom_range(0, 3);
            plan_n = (f == 3) ? 3 : f + 1;
            for (int a = 0; a < plan_n; a++) begin
                if (a < f) plan_kind[a] = ($urandom_range(0, 1) == 0) ? K_ERR : K_TMO;
                else       plan_kind[a] = ($urandom_range(0, 3) == 0) ? K_BOTH : K_ACK;
                plan_dly[a] = $urandom_range(0, 13);
            end
            fetch(AW'($urandom), DW'($urandom));
            if (f == 3) begin
                err_exit();
            end else if ($urandom_range(0, 3) == 0) begin
                do_abort();
            end else begin
                hold_check($urandom_range(0, 3), 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
